// File: rtl/ctrl_sequencer.sv
// Purpose: microcode sequencer stepping fetch/decode/execute T-states for the 8-bit bus CPU.
// Latency: control word is registered; a step's ops appear one posedge after the step is chosen.
// Backpressure: run_i=0 freezes the step counter and forces all ops idle; HALT holds until reset.
//
// Ports:
//   clock_i       system clock, all state changes on posedge
//   reset_ni      asynchronous active-low reset
//   instr_i       current IR contents (opcode in [7:4]); decoded from T2 onward
//   flag_c_i      carry flag, sampled on the edge entering T2 (JC)
//   flag_z_i      zero flag, sampled on the edge entering T2 (JZ)
//   run_i         1 = advance one step per clock, 0 = freeze
//   *_op_o        register ops, encoded 2'b00 NONE, 2'b01 LOAD, 2'b10 ENABLE
//   pc_inc_o      PC increments this step
//   alu_en_o      ALU result drives the bus
//   alu_sub_o     ALU computes A-B instead of A+B
//   flags_load_o  flags register captures ALU C/Z
//   halted_o      sequencer is in HALT
//   step_o        current T-state index
module ctrl_sequencer #(
   parameter int unsigned MAX_STEP = 5
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic [7:0] instr_i,
   input  logic       flag_c_i,
   input  logic       flag_z_i,
   input  logic       run_i,
   output logic [1:0] pc_op_o,
   output logic       pc_inc_o,
   output logic [1:0] mar_op_o,
   output logic [1:0] ram_op_o,
   output logic [1:0] ir_op_o,
   output logic [1:0] a_op_o,
   output logic [1:0] tmp_op_o,
   output logic [1:0] out_op_o,
   output logic       alu_en_o,
   output logic       alu_sub_o,
   output logic       flags_load_o,
   output logic       halted_o,
   output logic [2:0] step_o
);

   localparam logic [1:0] OP_NONE   = 2'b00;
   localparam logic [1:0] OP_LOAD   = 2'b01;
   localparam logic [1:0] OP_ENABLE = 2'b10;
   localparam logic [2:0] STEP_MAX  = 3'(MAX_STEP);

   typedef enum logic {ST_RUN, ST_HALT} state_e;

   typedef struct packed {
      logic [1:0] pc_op;
      logic       pc_inc;
      logic [1:0] mar_op;
      logic [1:0] ram_op;
      logic [1:0] ir_op;
      logic [1:0] a_op;
      logic [1:0] tmp_op;
      logic [1:0] out_op;
      logic       alu_en;
      logic       alu_sub;
      logic       flags_load;
   } ctrl_t;

   state_e     state_q, state_d;
   logic [2:0] step_q, step_d;
   // live_q: the ops of step_q are currently on the outputs. Cleared by reset and
   // by a frozen cycle, so the next running edge re-presents step_q instead of advancing.
   logic       live_q, live_d;
   ctrl_t      ctrl_q, ctrl_d;

   logic [3:0] opcode;
   logic [2:0] next_step;

   assign opcode = instr_i[7:4];

   // The operand nibble reaches the bus through the IR itself, not through this block.
   logic unused_operand;
   assign unused_operand = ^instr_i[3:0];

   // Last T-state of each instruction; the step after it is T0 again.
   function automatic logic [2:0] last_step(input logic [3:0] opc);
      case (opc)
         4'h1, 4'h4: last_step = 3'd3;
         4'h2, 4'h3: last_step = 3'd4;
         default:    last_step = 3'd2;
      endcase
   endfunction

   function automatic ctrl_t decode(input logic [2:0] stp, input logic [3:0] opc,
                                    input logic fc, input logic fz);
      ctrl_t c;
      c = '0;
      if (stp == 3'd0) begin
         c.pc_op  = OP_ENABLE;
         c.mar_op = OP_LOAD;
      end else if (stp == 3'd1) begin
         c.ram_op = OP_ENABLE;
         c.ir_op  = OP_LOAD;
         c.pc_inc = 1'b1;
      end else begin
         case (opc)
            4'h1, 4'h2, 4'h3, 4'h4: begin
               if (stp == 3'd2) begin
                  c.ir_op  = OP_ENABLE;
                  c.mar_op = OP_LOAD;
               end else if (stp == 3'd3) begin
                  if (opc == 4'h4) begin
                     c.a_op   = OP_ENABLE;
                     c.ram_op = OP_LOAD;
                  end else begin
                     c.ram_op = OP_ENABLE;
                     if (opc == 4'h1) c.a_op   = OP_LOAD;
                     else             c.tmp_op = OP_LOAD;
                  end
               end else if (stp == 3'd4 && (opc == 4'h2 || opc == 4'h3)) begin
                  c.alu_en     = 1'b1;
                  c.alu_sub    = (opc == 4'h3);
                  c.a_op       = OP_LOAD;
                  c.flags_load = 1'b1;
               end
            end
            4'h5: if (stp == 3'd2) begin
               c.ir_op = OP_ENABLE;
               c.a_op  = OP_LOAD;
            end
            // JMP, and JC/JZ when taken; flags are those present on this (T2 entry) edge.
            4'h6, 4'h7, 4'h8: if (stp == 3'd2 && (opc == 4'h6 || (opc == 4'h7 && fc) ||
                                                  (opc == 4'h8 && fz))) begin
               c.ir_op = OP_ENABLE;
               c.pc_op = OP_LOAD;
            end
            4'hE: if (stp == 3'd2) begin
               c.a_op   = OP_ENABLE;
               c.out_op = OP_LOAD;
            end
            default: c = '0;
         endcase
      end
      return c;
   endfunction

   // Saturating advance: running past the last legal step wraps to T0.
   assign next_step = (step_q >= STEP_MAX) ? 3'd0 : step_q + 3'd1;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      live_d  = live_q;
      ctrl_d  = '0;
      case (state_q)
         ST_RUN: begin
            if (!run_i) begin
               live_d = 1'b0;
            end else if (!live_q) begin
               live_d = 1'b1;
               ctrl_d = decode(step_q, opcode, flag_c_i, flag_z_i);
            end else if (step_q >= last_step(opcode)) begin
               if (opcode == 4'hF) begin
                  // HLT's T2 has retired: park with step frozen and ops idle.
                  state_d = ST_HALT;
                  live_d  = 1'b0;
               end else begin
                  step_d = 3'd0;
                  ctrl_d = decode(3'd0, opcode, flag_c_i, flag_z_i);
               end
            end else begin
               step_d = next_step;
               ctrl_d = decode(next_step, opcode, flag_c_i, flag_z_i);
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= ST_RUN;
         step_q  <= 3'd0;
         live_q  <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         live_q  <= live_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign pc_op_o      = ctrl_q.pc_op;
   assign pc_inc_o     = ctrl_q.pc_inc;
   assign mar_op_o     = ctrl_q.mar_op;
   assign ram_op_o     = ctrl_q.ram_op;
   assign ir_op_o      = ctrl_q.ir_op;
   assign a_op_o       = ctrl_q.a_op;
   assign tmp_op_o     = ctrl_q.tmp_op;
   assign out_op_o     = ctrl_q.out_op;
   assign alu_en_o     = ctrl_q.alu_en;
   assign alu_sub_o    = ctrl_q.alu_sub;
   assign flags_load_o = ctrl_q.flags_load;
   assign halted_o     = (state_q == ST_HALT);
   assign step_o       = step_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Purpose: directed and random stimulus for the microcode sequencer with a queue of expected words.
// Latency: expected word is queued before each clock and compared #1 after the posedge.
// Backpressure: run is driven explicitly to exercise freeze, resume and ignored-in-HALT cases.
module tb_ctrl_sequencer;

   localparam logic [1:0] N = 2'b00;
   localparam logic [1:0] L = 2'b01;
   localparam logic [1:0] E = 2'b10;

   typedef struct packed {
      logic [1:0] pc;
      logic       pc_inc;
      logic [1:0] mar;
      logic [1:0] ram;
      logic [1:0] ir;
      logic [1:0] a;
      logic [1:0] tmp;
      logic [1:0] outp;
      logic       alu_en;
      logic       alu_sub;
      logic       flags_load;
      logic       halted;
      logic [2:0] step;
   } obs_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] instr;
   logic       flag_c;
   logic       flag_z;
   logic       run;
   logic [1:0] pc_op, mar_op, ram_op, ir_op, a_op, tmp_op, out_op;
   logic       pc_inc, alu_en, alu_sub, flags_load, halted;
   logic [2:0] step;

   int   errors = 0;
   int   checks = 0;
   obs_t sb[$];

   ctrl_sequencer #(.MAX_STEP(5)) dut (
      .clock_i      (clk),
      .reset_ni     (rst_n),
      .instr_i      (instr),
      .flag_c_i     (flag_c),
      .flag_z_i     (flag_z),
      .run_i        (run),
      .pc_op_o      (pc_op),
      .pc_inc_o     (pc_inc),
      .mar_op_o     (mar_op),
      .ram_op_o     (ram_op),
      .ir_op_o      (ir_op),
      .a_op_o       (a_op),
      .tmp_op_o     (tmp_op),
      .out_op_o     (out_op),
      .alu_en_o     (alu_en),
      .alu_sub_o    (alu_sub),
      .flags_load_o (flags_load),
      .halted_o     (halted),
      .step_o       (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t idle(input logic [2:0] st);
      obs_t w;
      w = '0;
      w.step = st;
      return w;
   endfunction

   // Build a word from the register ops that usually matter; ALU bits are set by the caller.
   function automatic obs_t mk(input logic [2:0] st, input logic [1:0] pc, input logic [1:0] ir,
                               input logic [1:0] mar, input logic [1:0] ram,
                               input logic [1:0] a, input logic [1:0] tmp);
      obs_t w;
      w = idle(st);
      w.pc = pc; w.ir = ir; w.mar = mar; w.ram = ram; w.a = a; w.tmp = tmp;
      return w;
   endfunction

   function automatic obs_t t0();
      return mk(3'd0, E, N, L, N, N, N);
   endfunction

   function automatic obs_t t1();
      obs_t w;
      w = mk(3'd1, N, L, N, E, N, N);
      w.pc_inc = 1'b1;
      return w;
   endfunction

   function automatic obs_t sample();
      obs_t w;
      w.pc = pc_op; w.pc_inc = pc_inc; w.mar = mar_op; w.ram = ram_op; w.ir = ir_op;
      w.a = a_op; w.tmp = tmp_op; w.outp = out_op; w.alu_en = alu_en; w.alu_sub = alu_sub;
      w.flags_load = flags_load; w.halted = halted; w.step = step;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag);
      obs_t exp_w, act_w;
      exp_w = sb.pop_front();
      act_w = sample();
      checks++;
      assert (act_w === exp_w) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, act_w, exp_w);
      end
   endtask

   // Queue the expected word, clock the DUT, then compare what it produced.
   task automatic expect_step(input obs_t w, input string tag);
      sb.push_back(w);
      tick();
      check(tag);
   endtask

   function automatic int drivers();
      return int'(pc_op == E) + int'(ram_op == E) + int'(ir_op == E) + int'(a_op == E) +
             int'(alu_en);
   endfunction

   initial begin
      obs_t w;
      rst_n = 1'b0; run = 1'b0; instr = 8'h5A; flag_c = 1'b0; flag_z = 1'b0;
      #2;
      sb.push_back(idle(3'd0));
      check("reset_state");
      tick();
      rst_n = 1'b1; run = 1'b1;

      // LDI 10
      expect_step(t0(), "ldi_t0");
      expect_step(t1(), "ldi_t1");
      expect_step(mk(3'd2, N, E, N, N, L, N), "ldi_t2");
      expect_step(t0(), "ldi_wrap");

      // ADD 15 then SUB 15
      instr = 8'h2F;
      expect_step(t1(), "add_t1");
      expect_step(mk(3'd2, N, E, L, N, N, N), "add_t2");
      expect_step(mk(3'd3, N, N, N, E, N, L), "add_t3");
      w = mk(3'd4, N, N, N, N, L, N); w.alu_en = 1'b1; w.flags_load = 1'b1;
      expect_step(w, "add_t4");
      expect_step(t0(), "add_wrap");
      instr = 8'h3F;
      expect_step(t1(), "sub_t1");
      expect_step(mk(3'd2, N, E, L, N, N, N), "sub_t2");
      expect_step(mk(3'd3, N, N, N, E, N, L), "sub_t3");
      w = mk(3'd4, N, N, N, N, L, N); w.alu_en = 1'b1; w.alu_sub = 1'b1; w.flags_load = 1'b1;
      expect_step(w, "sub_t4");
      expect_step(t0(), "sub_wrap");

      // JC / JZ, each flag tested against the other's opposite value
      instr = 8'h73; flag_c = 1'b0; flag_z = 1'b1;
      expect_step(t1(), "jc_nt_t1");
      expect_step(idle(3'd2), "jc_not_taken");
      expect_step(t0(), "jc_nt_wrap");
      flag_c = 1'b1; flag_z = 1'b0;
      expect_step(t1(), "jc_t_t1");
      expect_step(mk(3'd2, L, E, N, N, N, N), "jc_taken");
      expect_step(t0(), "jc_t_wrap");
      instr = 8'h83; flag_c = 1'b1; flag_z = 1'b0;
      expect_step(t1(), "jz_nt_t1");
      expect_step(idle(3'd2), "jz_not_taken");
      expect_step(t0(), "jz_nt_wrap");
      flag_c = 1'b0; flag_z = 1'b1;
      expect_step(t1(), "jz_t_t1");
      expect_step(mk(3'd2, L, E, N, N, N, N), "jz_taken");
      expect_step(t0(), "jz_t_wrap");

      // Freeze for three cycles in ADD T3, then resume at T3
      instr = 8'h2F;
      expect_step(t1(), "frz_t1");
      expect_step(mk(3'd2, N, E, L, N, N, N), "frz_t2");
      expect_step(mk(3'd3, N, N, N, E, N, L), "frz_t3");
      run = 1'b0;
      for (int i = 0; i < 3; i++) expect_step(idle(3'd3), "frozen_t3");
      run = 1'b1;
      expect_step(mk(3'd3, N, N, N, E, N, L), "resume_t3");
      w = mk(3'd4, N, N, N, N, L, N); w.alu_en = 1'b1; w.flags_load = 1'b1;
      expect_step(w, "resume_t4");
      expect_step(t0(), "resume_wrap");

      // HLT: step frozen at 2, run ignored, only reset exits
      instr = 8'hF0;
      expect_step(t1(), "hlt_t1");
      expect_step(idle(3'd2), "hlt_t2");
      w = idle(3'd2); w.halted = 1'b1;
      expect_step(w, "halt_enter");
      for (int i = 0; i < 20; i++) begin
         run = i[0];
         expect_step(w, "halt_hold");
      end
      rst_n = 1'b0; run = 1'b1; instr = 8'h13;
      #1;
      sb.push_back(idle(3'd0));
      check("halt_reset");
      tick();
      rst_n = 1'b1;

      // LDA, reset asserted during T3 clears outputs before the next edge
      expect_step(t0(), "lda_t0");
      expect_step(t1(), "lda_t1");
      expect_step(mk(3'd2, N, E, L, N, N, N), "lda_t2");
      expect_step(mk(3'd3, N, N, N, E, L, N), "lda_t3");
      rst_n = 1'b0;
      #1;
      sb.push_back(idle(3'd0));
      check("reset_abort");
      tick();
      rst_n = 1'b1;
      expect_step(t0(), "restart_t0");

      // Random opcodes (HLT excluded so the run keeps moving)
      for (int i = 0; i < 1000; i++) begin
         instr  = {4'($urandom_range(0, 14)), 4'($urandom)};
         flag_c = 1'($urandom);
         flag_z = 1'($urandom);
         run    = ($urandom_range(0, 3) != 0);
         tick();
         checks++;
         assert (drivers() <= 1) else begin
            errors++;
            $error("FAIL bus_drivers: observed %0d drivers expected at most 1", drivers());
         end
         checks++;
         assert (step <= 3'd5 && halted === 1'b0) else begin
            errors++;
            $error("FAIL rand_state: observed step %0d halted %b expected step<=5 halted 0",
                   step, halted);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
